// File: rtl/rgb_led_pkg.sv
// Shared constants for the on-board RGB LED: active-low colour codes,
// display mode encoding and the rainbow palette lookup.
package rgb_led_pkg;

    localparam int unsigned LED_W   = 3;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned INDEX_W = 3;

    // Active-low codes, bit order {red, blue, green}
    localparam logic [LED_W-1:0] LED_RED     = 3'b011;
    localparam logic [LED_W-1:0] LED_YELLOW  = 3'b010;
    localparam logic [LED_W-1:0] LED_GREEN   = 3'b110;
    localparam logic [LED_W-1:0] LED_CYAN    = 3'b100;
    localparam logic [LED_W-1:0] LED_BLUE    = 3'b101;
    localparam logic [LED_W-1:0] LED_MAGENTA = 3'b001;
    localparam logic [LED_W-1:0] LED_WHITE   = 3'b000;
    localparam logic [LED_W-1:0] LED_OFF     = 3'b111;

    localparam logic [MODE_W-1:0] MODE_RAINBOW = 2'd0;
    localparam logic [MODE_W-1:0] MODE_BLINK   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_SOLID   = 2'd2;
    localparam logic [MODE_W-1:0] MODE_OFF     = 2'd3;

    localparam logic [INDEX_W-1:0] INDEX_LAST = 3'd5;

    function automatic logic [LED_W-1:0] palette(input logic [INDEX_W-1:0] index);
        logic [LED_W-1:0] code;
        case (index)
            3'd0:    code = LED_RED;
            3'd1:    code = LED_YELLOW;
            3'd2:    code = LED_GREEN;
            3'd3:    code = LED_CYAN;
            3'd4:    code = LED_BLUE;
            3'd5:    code = LED_MAGENTA;
            default: code = LED_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low push-button conditioner: two-flop synchronizer, stability counter
// and a single-cycle press pulse on the debounced falling edge.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_b,
    output logic press_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             differ_c;
    logic             settle_c;

    // The level flips on the last of DEBOUNCE_CYCLES consecutive disagreeing samples
    assign differ_c = (sync_2 != level);
    assign settle_c = differ_c && (cnt == CNT_LAST);
    assign press_c  = settle_c && level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_1 <= button_b;
            sync_2 <= sync_1;
            if (!differ_c) begin
                cnt <= '0;
            end else if (settle_c) begin
                cnt   <= '0;
                level <= sync_2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rgb_led_sequencer.sv
// Tang Nano RGB LED driver: button-stepped mode FSM (rainbow, blink, solid, off)
// with a shared step timer pacing colour changes and blinking.
module rgb_led_sequencer
    import rgb_led_pkg::*;
#(
    parameter int unsigned STEP_CYCLES     = 12_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button_b,
    output logic [LED_W-1:0]  led,
    output logic [MODE_W-1:0] mode,
    output logic              step_strobe
);

    localparam int unsigned STEP_W = $clog2(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic                press_c;
    logic                strobe_c;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_cnt_next;
    logic [MODE_W-1:0]   mode_next;
    logic [INDEX_W-1:0]  index;
    logic [INDEX_W-1:0]  index_next;
    logic                phase;
    logic                phase_next;
    logic [LED_W-1:0]    led_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk     (clk),
        .rst     (rst),
        .button_b(button_b),
        .press_c (press_c)
    );

    assign strobe_c = (step_cnt == STEP_LAST);

    // Next-state: a press outranks a coincident strobe and restarts the step
    always_comb begin
        mode_next     = mode;
        index_next    = index;
        phase_next    = phase;
        step_cnt_next = step_cnt + STEP_W'(1);
        if (press_c) begin
            step_cnt_next = '0;
            phase_next    = 1'b1;
            case (mode)
                MODE_RAINBOW: mode_next = MODE_BLINK;
                MODE_BLINK:   mode_next = MODE_SOLID;
                MODE_SOLID:   mode_next = MODE_OFF;
                default:      mode_next = MODE_RAINBOW;
            endcase
        end else if (strobe_c) begin
            step_cnt_next = '0;
            case (mode)
                MODE_RAINBOW: index_next = (index == INDEX_LAST) ? '0 : index + INDEX_W'(1);
                MODE_BLINK:   phase_next = !phase;
                default:      ;
            endcase
        end
    end

    // Output colour from the current registered state
    always_comb begin
        led_next = LED_OFF;
        case (mode)
            MODE_RAINBOW: led_next = palette(index);
            MODE_BLINK:   led_next = phase ? palette(index) : LED_OFF;
            MODE_SOLID:   led_next = palette(index);
            default:      led_next = LED_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= MODE_RAINBOW;
            index       <= '0;
            phase       <= 1'b1;
            step_cnt    <= '0;
            step_strobe <= 1'b0;
            led         <= LED_OFF;
        end else begin
            mode        <= mode_next;
            index       <= index_next;
            phase       <= phase_next;
            step_cnt    <= step_cnt_next;
            step_strobe <= strobe_c;
            led         <= led_next;
        end
    end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Scoreboard bench for rgb_led_sequencer with STEP_CYCLES=4, DEBOUNCE_CYCLES=3:
// scenarios queue expected output changes and cycle probes; a monitor checks them.
module tb_rgb_led_sequencer;

    typedef struct {
        int         cyc;
        logic [2:0] led;
        logic [1:0] mode;
    } chg_t;

    typedef struct {
        int         cyc;
        logic [2:0] led;
        logic [1:0] mode;
        logic       strobe;
    } probe_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button_b = 1'b1;
    logic [2:0] led;
    logic [1:0] mode;
    logic       step_strobe;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    logic   mon_en = 1'b0;
    logic [4:0] last = 5'b0;
    chg_t   chg_q[$];
    probe_t probe_q[$];
    chg_t   e;
    probe_t p;

    logic [2:0] rainbow_tab [0:6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};

    rgb_led_sequencer #(
        .STEP_CYCLES    (4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_b   (button_b),
        .led        (led),
        .mode       (mode),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen; outputs sampled 1 ns after each
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mon_en && ({led, mode} !== last)) begin
            checks = checks + 1;
            if (chg_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL chg_unexpected cyc=%0d: got led=%b mode=%0d, required no change", cyc, led, mode);
            end else begin
                e = chg_q.pop_front();
                if (e.cyc != cyc || led !== e.led || mode !== e.mode) begin
                    errors = errors + 1;
                    $display("FAIL chg cyc=%0d: got led=%b mode=%0d, required led=%b mode=%0d at cyc=%0d",
                             cyc, led, mode, e.led, e.mode, e.cyc);
                end
            end
        end
        while (chg_q.size() > 0 && chg_q[0].cyc < cyc) begin
            e = chg_q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL chg_missed cyc=%0d: got led=%b mode=%0d, required led=%b mode=%0d at cyc=%0d",
                     cyc, led, mode, e.led, e.mode, e.cyc);
        end
        last = {led, mode};
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            checks = checks + 1;
            if (p.cyc != cyc || led !== p.led || mode !== p.mode || step_strobe !== p.strobe) begin
                errors = errors + 1;
                $display("FAIL probe cyc=%0d: got led=%b mode=%0d strobe=%b, required led=%b mode=%0d strobe=%b (cyc=%0d)",
                         cyc, led, mode, step_strobe, p.led, p.mode, p.strobe, p.cyc);
            end
        end
    end

    task automatic push_chg(input int c, input logic [2:0] l, input logic [1:0] m);
        chg_q.push_back('{c, l, m});
    endtask

    task automatic push_probe(input int c, input logic [2:0] l, input logic [1:0] m, input logic s);
        probe_q.push_back('{c, l, m, s});
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Button goes low on the falling edge after rising edge c, high again after c+hold
    task automatic press_at(input int c, input int hold);
        wait_cyc(c);
        button_b = 1'b0;
        wait_cyc(c + hold);
        button_b = 1'b1;
    endtask

    initial begin
        // Reset, then rainbow with one full wrap
        push_probe(1, 3'b111, 2'd0, 1'b0);
        push_probe(2, 3'b111, 2'd0, 1'b0);
        push_probe(5, 3'b011, 2'd0, 1'b0);
        push_probe(6, 3'b011, 2'd0, 1'b1);
        push_probe(7, 3'b010, 2'd0, 1'b0);
        for (int k = 0; k < 7; k++) push_chg(3 + 4 * k, rainbow_tab[k], 2'd0);
        wait_cyc(2);
        rst = 1'b0;
        mon_en = 1'b1;

        // Clean 8-cycle press at index 2, then blink of green
        wait_cyc(28);
        push_chg(31, 3'b010, 2'd0);
        push_chg(35, 3'b110, 2'd0);
        push_chg(36, 3'b110, 2'd1);
        push_chg(41, 3'b111, 2'd1);
        push_chg(45, 3'b110, 2'd1);
        push_probe(39, 3'b110, 2'd1, 1'b0);
        push_probe(40, 3'b110, 2'd1, 1'b1);
        press_at(31, 8);

        // Two-cycle glitch: blink carries on undisturbed
        push_chg(49, 3'b111, 2'd1);
        push_chg(53, 3'b110, 2'd1);
        press_at(45, 2);

        // One-cycle reset mid-blink
        push_chg(55, 3'b111, 2'd0);
        push_chg(56, 3'b011, 2'd0);
        push_chg(60, 3'b010, 2'd0);
        push_chg(64, 3'b110, 2'd0);
        push_chg(68, 3'b100, 2'd0);
        push_probe(55, 3'b111, 2'd0, 1'b0);
        push_probe(59, 3'b011, 2'd0, 1'b1);
        wait_cyc(54);
        rst = 1'b1;
        wait_cyc(55);
        rst = 1'b0;

        // Press lands on the strobe at index 3: index held, step restarts
        push_chg(71, 3'b100, 2'd1);
        push_chg(76, 3'b111, 2'd1);
        push_chg(80, 3'b100, 2'd1);
        push_probe(70, 3'b100, 2'd0, 1'b0);
        push_probe(71, 3'b100, 2'd1, 1'b1);
        push_probe(72, 3'b100, 2'd1, 1'b0);
        push_probe(74, 3'b100, 2'd1, 1'b0);
        push_probe(75, 3'b100, 2'd1, 1'b1);
        push_probe(76, 3'b111, 2'd1, 1'b0);
        press_at(66, 4);

        // Remaining wrap: SOLID, OFF, back to RAINBOW resuming at cyan
        push_chg(84, 3'b111, 2'd2);
        push_chg(85, 3'b100, 2'd2);
        push_chg(95, 3'b100, 2'd3);
        push_chg(96, 3'b111, 2'd3);
        push_chg(106, 3'b111, 2'd0);
        push_chg(107, 3'b100, 2'd0);
        push_chg(111, 3'b101, 2'd0);
        push_probe(96, 3'b111, 2'd3, 1'b0);
        push_probe(110, 3'b100, 2'd0, 1'b1);
        push_probe(111, 3'b101, 2'd0, 1'b0);
        press_at(79, 4);
        press_at(90, 4);
        press_at(101, 4);

        wait_cyc(114);
        checks = checks + 1;
        if (chg_q.size() != 0 || probe_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d changes and %0d probes pending, required 0 and 0",
                     chg_q.size(), probe_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got cyc=%0d, required end by cyc 114", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rgb_led_sequencer.md
# rgb_led_sequencer

Drives the Tang Nano on-board RGB LED, selecting between four display modes: rainbow cycle, blink, solid and off. A debounced user button steps through the modes. The block owns the active-low `led[2:0]` pins and replaces ad-hoc per-design LED logic at the top level. A per-step timer paces colour changes and blinking.

## Interface

Parameters:

- `STEP_CYCLES`, default 12_000_000. Clock cycles per step (0.5 s at 24 MHz). Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 240_000. Cycles the synchronized button level must be stable before it is accepted (10 ms). Must be ≥ 2.

Ports:

- `clk`, input, 1 bit. Single system clock.
- `rst`, input, 1 bit. Reset: synchronous, active-high.
- `button_b`, input, 1 bit. Raw mode button, active-low, asynchronous to `clk`.
- `led`, output, 3 bits. Active-low RGB: `[2]` red, `[1]` blue, `[0]` green.
- `mode`, output, 2 bits. Current mode: 0 RAINBOW, 1 BLINK, 2 SOLID, 3 OFF.
- `step_strobe`, output, 1 bit. One-cycle pulse at the end of each step.

## Operation

- **Palette index 0..5** (active-low codes):
  - 0: RED 011
  - 1: YELLOW 010
  - 2: GREEN 110
  - 3: CYAN 100
  - 4: BLUE 101
  - 5: MAGENTA 001
  - OFF is 111.
- **Button path:**
  - Two-flop synchronizer feeds a debounce counter.
  - The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing sample clears the counter.
  - A press event is a debounced 1→0 transition.
- **Mode FSM:** RAINBOW→BLINK→SOLID→OFF→RAINBOW, advancing one state per press event.
- **Step timer:**
  - Counts 0..`STEP_CYCLES`-1 in every mode.
  - `step_strobe` is high when the count equals `STEP_CYCLES`-1; the count then wraps to 0.
- **RAINBOW:** index advances on each strobe, wrapping 5→0. `led` = palette[index].
- **BLINK:**
  - Index is frozen.
  - Blink phase toggles on each strobe.
  - `led` = palette[index] when phase is on, 111 when off.
- **SOLID:** index is frozen; `led` = palette[index].
- **OFF:** index is frozen; `led` = 111.
- **On a press event:**
  - Mode advances.
  - Step counter clears to 0.
  - Blink phase is set to on.
  - Index is retained, so re-entering RAINBOW resumes from the frozen colour.
- **Press and strobe in the same cycle:** the press wins. Index is not advanced, phase is not toggled, counter clears.
- **Button held through reset:** the debounced level resets to 1, so the held button is accepted as a press `DEBOUNCE_CYCLES` cycles after the synchronizer output goes low.

## Timing

- **Reset** (`rst` high at a `clk` edge), values after that edge:
  - `mode`=0, index=0, phase=on, counter=0, debounce counter=0, debounced level=1.
  - Synchronizer flops=1, `step_strobe`=0, `led`=111.
- **First edge with `rst` low:** `led` becomes 011 (RED).
- **`led` and `step_strobe` are registered.**
  - `led` reflects mode/index/phase with 1-cycle latency.
  - `step_strobe` is high in the cycle after the counter reaches `STEP_CYCLES`-1.
- **Press latency:** 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles to the press event. `mode` updates at the next edge; `led` one cycle later.
- **Register widths:**
  - Step counter: `$clog2(STEP_CYCLES)`.
  - Debounce counter: `$clog2(DEBOUNCE_CYCLES+1)`.
  - Index: 3 bits, never exceeds 5.
- **Reset mid-operation:** aborts everything, with the values above at the next edge. A debounce in progress is discarded.

## Structure

- **Shared package `rgb_led_pkg`** holds:
  - The colour localparams (the eight active-low codes).
  - The mode encoding constants.
  - The `palette(index)` function.
- **Sub-module `button_debounce`** contains the synchronizer, the debounce counter and press-pulse generation. It is parameterized by `DEBOUNCE_CYCLES` and reused for `button_a` elsewhere.
- **Top module** contains the mode FSM, step timer, index/phase registers and output register.

## Test plan

All scenarios use `STEP_CYCLES`=4 and `DEBOUNCE_CYCLES`=3.

- **Reset and rainbow sequence:** reset for 2 cycles, then release.
  - `led`=111 during reset, then 011.
  - `led` steps 010, 110, 100, 101, 001 at 4-cycle intervals.
  - `led` wraps to 011 after 24 cycles.
- **Clean press:** hold `button_b` low for 8 cycles.
  - `mode` goes 0→1 exactly 5 cycles after the fall (2 sync + 3 debounce).
  - `led` alternates the frozen colour and 111 every 4 cycles, starting with the colour on.
- **Glitch rejection:** `button_b` low for 2 cycles, then high. `mode` unchanged and no press event.
- **Press coincident with strobe:** align the press event with `step_strobe`.
  - Index unchanged.
  - Next strobe occurs 4 cycles after the press.
- **Mode wrap:** four separate clean presses from RAINBOW at index 3.
  - Sequence is BLINK, SOLID, OFF (`led`=111), RAINBOW.
  - RAINBOW resumes at 100 (CYAN).
- **Reset mid-blink:** assert `rst` for 1 cycle while in BLINK at index 2.
  - Next edge: `mode`=0, `led`=111.
  - Then `led` shows 011.
